instr_fetch_32: RTL and testbench
=================================

INSTR_FETCH_32 -- requirements
Module: instr_fetch_32

Interface
REQ-001 Parameter TIMEOUT, 16, max cycles in REQ without mem_ack before abort; legal range 2..255.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 pc_addr  input  32  fetch address from the PC stage.
REQ-005 pc_valid  input  1  pc_addr is valid this cycle and fetch is requested.
REQ-006 flush  input  1  synchronous abort of any fetch; invalidates the hit buffer.
REQ-007 mem_req  output  1  registered request to instruction memory.
REQ-008 mem_addr  output  32  registered word address for memory, bits [1:0] always 0.
REQ-009 mem_ack  input  1  memory returns data this cycle.
REQ-010 mem_rdata  input  32  instruction word, sampled only when mem_ack=1 in REQ.
REQ-011 instruction  output  32  registered fetched instruction to the decode stage.
REQ-012 instr_valid  output  1  registered one-cycle pulse; instruction is new.
REQ-013 stall  output  1  combinational; holds the PC stage.
REQ-014 misaligned  output  1  registered one-cycle pulse; pc_addr[1:0]!=0.
REQ-015 fetch_fault  output  1  registered one-cycle pulse; TIMEOUT expired.

Function
REQ-016 States: IDLE, REQ; 2-bit or 1-bit encoding; no other reachable state.
REQ-017 Hit buffer: buf_valid (1b), buf_tag (32b), buf_data (32b); hit = buf_valid & (pc_addr==buf_tag).
REQ-018 IDLE, pc_valid, pc_addr[1:0]!=0 -> misaligned=1 next cycle; no memory access; stay IDLE; instruction unchanged.
REQ-019 IDLE, pc_valid, aligned, hit -> instruction<=buf_data, instr_valid=1 next cycle; stay IDLE; mem_req stays 0.
REQ-020 IDLE, pc_valid, aligned, miss -> mem_addr<=pc_addr, mem_req<=1, timeout counter<=0; go REQ.
REQ-021 REQ: mem_req held 1 and mem_addr held constant until mem_ack, flush, or timeout.
REQ-022 REQ with mem_ack=1 -> instruction<=mem_rdata, buf_data<=mem_rdata, buf_tag<=mem_addr, buf_valid<=1, instr_valid=1, mem_req<=0 next cycle; go IDLE.
REQ-023 Fetch latency: hit 1 cycle; miss 1 cycle (REQ entry) + N ack cycles + 1 (capture edge).
REQ-024 Timeout counter 8-bit, increments each REQ cycle without ack; reaching TIMEOUT-1 without ack -> fetch_fault=1, mem_req<=0, buf_valid<=0, go IDLE; counter does not wrap.
REQ-025 mem_ack and timeout in same cycle: ack wins, no fault.
REQ-026 flush=1 (any state): next cycle mem_req=0, buf_valid=0, state IDLE, instr_valid=0, misaligned=0, fetch_fault=0; mem_ack in that cycle ignored; pc_valid in that cycle ignored.
REQ-027 mem_ack while IDLE: ignored, no state change.
REQ-028 stall = (state==REQ) | (state==IDLE & pc_valid & aligned & ~hit & ~flush).
REQ-029 instr_valid, misaligned, fetch_fault mutually exclusive; each at most one cycle per fetch.
REQ-030 pc_valid changes during REQ: ignored; new address fetched only after return to IDLE.

Reset
REQ-031 reset=1: immediately state=IDLE, mem_req=0, mem_addr=0, instruction=0, instr_valid=0, misaligned=0, fetch_fault=0, buf_valid=0, buf_tag=0, buf_data=0, counter=0.
REQ-032 reset asserted mid-REQ: request dropped without waiting for mem_ack; a later mem_ack is ignored.
REQ-033 First clock edge after reset release operates normally from IDLE.

Verification
REQ-034 pc_addr=0x00400000, pc_valid=1, mem_ack after 3 REQ cycles with 0x20080005 -> mem_req high 3 cycles, mem_addr=0x00400000, instruction=0x20080005, one instr_valid pulse, stall high until capture.
REQ-035 Repeat pc_addr=0x00400000 after scenario above -> instr_valid next cycle, instruction=0x20080005, mem_req never asserted, stall=0.
REQ-036 pc_addr=0x00400002, pc_valid=1 -> misaligned pulse one cycle, mem_req=0, instr_valid=0.
REQ-037 Miss at 0x00400004, mem_ack never asserted, TIMEOUT=16 -> fetch_fault pulse after 16 REQ cycles, mem_req drops, buf_valid=0.
REQ-038 flush asserted in 2nd REQ cycle together with mem_ack=1, mem_rdata=0xDEADBEEF -> mem_req=0 next cycle, instr_valid=0, instruction unchanged, subsequent same-address fetch misses.
REQ-039 reset pulsed asynchronously (between edges) mid-REQ -> all outputs 0 before next clk edge; stale mem_ack ignored.

Source files
------------

// File: rtl/instr_fetch_32.sv
// Instruction fetch stage: single-entry hit buffer in front of a request/ack memory port,
// with alignment check, request timeout and synchronous flush.
module instr_fetch_32 #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_addr,
    input  logic        pc_valid,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic        stall,
    output logic        misaligned,
    output logic        fetch_fault
);

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("instr_fetch_32: TIMEOUT must be in 2..255");
    end

    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        StIdle,
        StReq
    } state_e;

    state_e      r_state;
    logic        r_mem_req;
    logic [31:0] r_mem_addr;
    logic [31:0] r_instruction;
    logic        r_instr_valid;
    logic        r_misaligned;
    logic        r_fetch_fault;
    logic        r_buf_valid;
    logic [31:0] r_buf_tag;
    logic [31:0] r_buf_data;
    logic [7:0]  r_cnt;

    state_e      w_state_nxt;
    logic        w_mem_req_nxt;
    logic [31:0] w_mem_addr_nxt;
    logic [31:0] w_instruction_nxt;
    logic        w_instr_valid_nxt;
    logic        w_misaligned_nxt;
    logic        w_fetch_fault_nxt;
    logic        w_buf_valid_nxt;
    logic [31:0] w_buf_tag_nxt;
    logic [31:0] w_buf_data_nxt;
    logic [7:0]  w_cnt_nxt;

    logic        w_aligned;
    logic        w_hit;

    assign w_aligned = (pc_addr[1:0] == 2'b00);
    assign w_hit     = r_buf_valid && (pc_addr == r_buf_tag);

    always_comb begin
        w_state_nxt       = r_state;
        w_mem_req_nxt     = r_mem_req;
        w_mem_addr_nxt    = r_mem_addr;
        w_instruction_nxt = r_instruction;
        w_instr_valid_nxt = 1'b0;
        w_misaligned_nxt  = 1'b0;
        w_fetch_fault_nxt = 1'b0;
        w_buf_valid_nxt   = r_buf_valid;
        w_buf_tag_nxt     = r_buf_tag;
        w_buf_data_nxt    = r_buf_data;
        w_cnt_nxt         = r_cnt;

        if (flush) begin
            // Flush overrides everything, including an ack or new PC in the same cycle.
            w_state_nxt     = StIdle;
            w_mem_req_nxt   = 1'b0;
            w_buf_valid_nxt = 1'b0;
            w_cnt_nxt       = 8'd0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (pc_valid) begin
                        if (!w_aligned) begin
                            w_misaligned_nxt = 1'b1;
                        end else if (w_hit) begin
                            w_instruction_nxt = r_buf_data;
                            w_instr_valid_nxt = 1'b1;
                        end else begin
                            w_mem_addr_nxt = {pc_addr[31:2], 2'b00};
                            w_mem_req_nxt  = 1'b1;
                            w_cnt_nxt      = 8'd0;
                            w_state_nxt    = StReq;
                        end
                    end
                end
                StReq: begin
                    // Ack is checked first so it wins over a simultaneous timeout.
                    if (mem_ack) begin
                        w_instruction_nxt = mem_rdata;
                        w_buf_data_nxt    = mem_rdata;
                        w_buf_tag_nxt     = r_mem_addr;
                        w_buf_valid_nxt   = 1'b1;
                        w_instr_valid_nxt = 1'b1;
                        w_mem_req_nxt     = 1'b0;
                        w_state_nxt       = StIdle;
                    end else if (r_cnt == CntLast) begin
                        w_fetch_fault_nxt = 1'b1;
                        w_mem_req_nxt     = 1'b0;
                        w_buf_valid_nxt   = 1'b0;
                        w_state_nxt       = StIdle;
                    end else if (r_cnt != 8'hFF) begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
                default: begin
                    w_state_nxt   = StIdle;
                    w_mem_req_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= StIdle;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= 32'd0;
            r_instruction <= 32'd0;
            r_instr_valid <= 1'b0;
            r_misaligned  <= 1'b0;
            r_fetch_fault <= 1'b0;
            r_buf_valid   <= 1'b0;
            r_buf_tag     <= 32'd0;
            r_buf_data    <= 32'd0;
            r_cnt         <= 8'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_mem_req     <= w_mem_req_nxt;
            r_mem_addr    <= w_mem_addr_nxt;
            r_instruction <= w_instruction_nxt;
            r_instr_valid <= w_instr_valid_nxt;
            r_misaligned  <= w_misaligned_nxt;
            r_fetch_fault <= w_fetch_fault_nxt;
            r_buf_valid   <= w_buf_valid_nxt;
            r_buf_tag     <= w_buf_tag_nxt;
            r_buf_data    <= w_buf_data_nxt;
            r_cnt         <= w_cnt_nxt;
        end
    end

    assign stall = (r_state == StReq) ||
                   ((r_state == StIdle) && pc_valid && w_aligned && !w_hit && !flush);

    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;
    assign instruction = r_instruction;
    assign instr_valid = r_instr_valid;
    assign misaligned  = r_misaligned;
    assign fetch_fault = r_fetch_fault;

endmodule

// File: tb/tb_instr_fetch_32.sv
// Directed bench for instr_fetch_32: miss/hit, misalignment, timeout, flush and async reset.
module tb_instr_fetch_32;

    logic        clk;
    logic        reset;
    logic [31:0] pc_addr;
    logic        pc_valid;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        stall;
    logic        misaligned;
    logic        fetch_fault;

    int n_vec = 0;
    int n_bad = 0;

    instr_fetch_32 #(.TIMEOUT(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_addr     (pc_addr),
        .pc_valid    (pc_valid),
        .flush       (flush),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .stall       (stall),
        .misaligned  (misaligned),
        .fetch_fault (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;

        reset     = 1'b1;
        pc_addr   = 32'd0;
        pc_valid  = 1'b0;
        flush     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        #12;
        check_eq("rst_mem_req", 32'(mem_req), 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_instr", instruction, 32'd0);
        check_eq("rst_flags", {29'd0, instr_valid, misaligned, fetch_fault}, 32'd0);
        check_eq("rst_stall", 32'(stall), 32'd0);
        reset = 1'b0;
        step();

        // Miss at 0x00400000, ack on the 3rd REQ cycle.
        pc_addr  = 32'h0040_0000;
        pc_valid = 1'b1;
        #1;
        check_eq("miss_stall_idle", 32'(stall), 32'd1);
        step();
        check_eq("miss_req", 32'(mem_req), 32'd1);
        check_eq("miss_addr", mem_addr, 32'h0040_0000);
        pc_valid = 1'b0;
        pc_addr  = 32'h0050_0000;
        n = 0;
        for (int k = 1; k <= 3; k++) begin
            if (mem_req) n++;
            mem_ack   = (k == 3);
            mem_rdata = (k == 3) ? 32'h2008_0005 : 32'hFFFF_FFFF;
            #1;
            check_eq("miss_stall_req", 32'(stall), 32'd1);
            step();
        end
        mem_ack = 1'b0;
        check_eq("miss_req_cycles", n, 32'd3);
        check_eq("miss_req_drop", 32'(mem_req), 32'd0);
        check_eq("miss_addr_held", mem_addr, 32'h0040_0000);
        check_eq("miss_instr", instruction, 32'h2008_0005);
        check_eq("miss_ivalid", 32'(instr_valid), 32'd1);
        check_eq("miss_stall_done", 32'(stall), 32'd0);
        step();
        check_eq("miss_ivalid_pulse", 32'(instr_valid), 32'd0);

        // Same address again: buffer hit.
        pc_addr  = 32'h0040_0000;
        pc_valid = 1'b1;
        #1;
        check_eq("hit_stall", 32'(stall), 32'd0);
        step();
        pc_valid = 1'b0;
        check_eq("hit_ivalid", 32'(instr_valid), 32'd1);
        check_eq("hit_instr", instruction, 32'h2008_0005);
        check_eq("hit_req", 32'(mem_req), 32'd0);
        step();
        check_eq("hit_ivalid_pulse", 32'(instr_valid), 32'd0);

        // Misaligned address.
        pc_addr  = 32'h0040_0002;
        pc_valid = 1'b1;
        #1;
        check_eq("mis_stall", 32'(stall), 32'd0);
        step();
        pc_valid = 1'b0;
        check_eq("mis_flag", 32'(misaligned), 32'd1);
        check_eq("mis_req", 32'(mem_req), 32'd0);
        check_eq("mis_ivalid", 32'(instr_valid), 32'd0);
        check_eq("mis_instr", instruction, 32'h2008_0005);
        step();
        check_eq("mis_pulse", 32'(misaligned), 32'd0);

        // Timeout: no ack ever, fault after 16 REQ cycles.
        pc_addr  = 32'h0040_0004;
        pc_valid = 1'b1;
        step();
        pc_valid = 1'b0;
        n = 0;
        while (mem_req === 1'b1 && n < 40) begin
            n++;
            step();
        end
        check_eq("to_cycles", n, 32'd16);
        check_eq("to_fault", 32'(fetch_fault), 32'd1);
        check_eq("to_ivalid", 32'(instr_valid), 32'd0);
        step();
        check_eq("to_fault_pulse", 32'(fetch_fault), 32'd0);
        // Buffer was invalidated, so the old hit address now misses.
        pc_addr  = 32'h0040_0000;
        pc_valid = 1'b1;
        #1;
        check_eq("to_buf_inval", 32'(stall), 32'd1);
        step();
        pc_valid = 1'b0;
        flush    = 1'b1;
        step();
        flush = 1'b0;
        check_eq("abort_req", 32'(mem_req), 32'd0);

        // Ack arriving in the same cycle the timeout would fire: ack wins.
        pc_addr  = 32'h0040_0008;
        pc_valid = 1'b1;
        step();
        pc_valid = 1'b0;
        for (int k = 1; k <= 15; k++) step();
        check_eq("race_req_still", 32'(mem_req), 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1111_2222;
        step();
        mem_ack = 1'b0;
        check_eq("race_ivalid", 32'(instr_valid), 32'd1);
        check_eq("race_fault", 32'(fetch_fault), 32'd0);
        check_eq("race_instr", instruction, 32'h1111_2222);
        step();

        // Flush in the 2nd REQ cycle together with an ack.
        pc_addr  = 32'h0040_0010;
        pc_valid = 1'b1;
        step();
        pc_valid = 1'b0;
        step();
        flush     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        step();
        flush   = 1'b0;
        mem_ack = 1'b0;
        check_eq("fl_req", 32'(mem_req), 32'd0);
        check_eq("fl_ivalid", 32'(instr_valid), 32'd0);
        check_eq("fl_instr", instruction, 32'h1111_2222);
        pc_addr  = 32'h0040_0008;
        pc_valid = 1'b1;
        #1;
        check_eq("fl_buf_cleared", 32'(stall), 32'd1);
        pc_addr = 32'h0040_0010;
        #1;
        check_eq("fl_refetch_miss", 32'(stall), 32'd1);
        step();
        pc_valid = 1'b0;
        check_eq("fl_refetch_req", 32'(mem_req), 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h3333_4444;
        step();
        mem_ack = 1'b0;
        check_eq("fl_refetch_instr", instruction, 32'h3333_4444);
        step();

        // Asynchronous reset mid-REQ, then a stale ack.
        pc_addr  = 32'h0040_0020;
        pc_valid = 1'b1;
        step();
        pc_valid = 1'b0;
        check_eq("ar_req_before", 32'(mem_req), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("ar_req", 32'(mem_req), 32'd0);
        check_eq("ar_addr", mem_addr, 32'd0);
        check_eq("ar_instr", instruction, 32'd0);
        check_eq("ar_stall", 32'(stall), 32'd0);
        reset     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_6666;
        step();
        mem_ack = 1'b0;
        check_eq("ar_stale_ivalid", 32'(instr_valid), 32'd0);
        check_eq("ar_stale_instr", instruction, 32'd0);
        check_eq("ar_stale_req", 32'(mem_req), 32'd0);
        pc_addr  = 32'h0040_0000;
        pc_valid = 1'b1;
        #1;
        check_eq("ar_buf_empty", 32'(stall), 32'd1);
        step();
        pc_valid = 1'b0;
        check_eq("ar_normal_req", 32'(mem_req), 32'd1);
        check_eq("ar_normal_addr", mem_addr, 32'h0040_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
